// File: rtl/acc_ctrl_seq.sv
// Multi-cycle control unit for the 8-bit accumulator datapath: fetches, decodes and sequences
// instructions, owning the program counter and instruction register.
module acc_ctrl_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              acc_zero,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic              a_ce,
  output logic [2:0]        alu_op,
  output logic              b_sel,
  output logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemRd,
    StExec,
    StHalt
  } state_e;

  localparam logic [OPC_W-1:0] OpLda = OPC_W'(1);
  localparam logic [OPC_W-1:0] OpSta = OPC_W'(2);
  localparam logic [OPC_W-1:0] OpAdd = OPC_W'(3);
  localparam logic [OPC_W-1:0] OpSub = OPC_W'(4);
  localparam logic [OPC_W-1:0] OpAnd = OPC_W'(5);
  localparam logic [OPC_W-1:0] OpOr  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OpJmp = OPC_W'(7);
  localparam logic [OPC_W-1:0] OpJz  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OpLdi = OPC_W'(9);
  localparam logic [OPC_W-1:0] OpHlt = OPC_W'(15);

  localparam logic [2:0] AluPass = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd1;
  localparam logic [2:0] AluSub  = 3'd2;
  localparam logic [2:0] AluAnd  = 3'd3;
  localparam logic [2:0] AluOr   = 3'd4;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [OPC_W-1:0]    ir_opc, rd_opc;
  logic [ADDR_W-1:0]   ir_addr;

  assign ir_opc  = ir_q[DATA_W-1 -: OPC_W];
  assign ir_addr = ir_q[ADDR_W-1:0];
  assign rd_opc  = mem_rdata[DATA_W-1 -: OPC_W];
  assign pc      = pc_q;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return opc inside {OpLda, OpAdd, OpSub, OpAnd, OpOr};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mem_addr = pc_q;
    mem_rd   = 1'b0;
    mem_we   = 1'b0;
    a_ce     = 1'b0;
    alu_op   = AluPass;
    b_sel    = 1'b0;
    imm      = {{(DATA_W-ADDR_W){1'b0}}, ir_addr};
    busy     = 1'b0;
    halted   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        busy    = 1'b1;
        mem_rd  = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        busy    = 1'b1;
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = is_mem_op(rd_opc) ? StMemRd : StExec;
      end
      StMemRd: begin
        busy     = 1'b1;
        mem_addr = ir_addr;
        mem_rd   = 1'b1;
        state_d  = StExec;
      end
      StExec: begin
        busy    = 1'b1;
        state_d = StFetch;
        case (ir_opc)
          OpLda: begin a_ce = 1'b1; alu_op = AluPass; end
          OpAdd: begin a_ce = 1'b1; alu_op = AluAdd;  end
          OpSub: begin a_ce = 1'b1; alu_op = AluSub;  end
          OpAnd: begin a_ce = 1'b1; alu_op = AluAnd;  end
          OpOr:  begin a_ce = 1'b1; alu_op = AluOr;   end
          OpLdi: begin a_ce = 1'b1; b_sel = 1'b1;     end
          OpSta: begin
            mem_addr = ir_addr;
            mem_we   = 1'b1;
          end
          OpJmp: pc_d = ir_addr;
          OpJz:  if (acc_zero) pc_d = ir_addr;
          OpHlt: state_d = StHalt;
          default: ;  // undefined opcodes behave as NOP
        endcase
      end
      StHalt: begin
        halted = 1'b1;
        if (start) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes must drop in the very cycle reset rises so no partial write escapes.
    if (rst) begin
      mem_addr = '0;
      mem_rd   = 1'b0;
      mem_we   = 1'b0;
      a_ce     = 1'b0;
      alu_op   = AluPass;
      b_sel    = 1'b0;
      imm      = '0;
      busy     = 1'b0;
      halted   = 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_ctrl_seq.sv
// Self-checking bench for acc_ctrl_seq: a behavioural datapath plus an instruction-level
// reference interpreter that predicts final state, cycle counts and strobe counts.
module tb_acc_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] mem_rdata;
  logic       acc_zero;
  logic [3:0] mem_addr;
  logic       mem_rd, mem_we, a_ce, b_sel, busy, halted;
  logic [2:0] alu_op;
  logic [7:0] imm;
  logic [3:0] pc;

  always #5 clk = ~clk;

  acc_ctrl_seq #(.DATA_W(8), .ADDR_W(4), .OPC_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_rdata(mem_rdata), .acc_zero(acc_zero),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .a_ce(a_ce), .alu_op(alu_op),
    .b_sel(b_sel), .imm(imm), .pc(pc), .busy(busy), .halted(halted)
  );

  // Datapath: synchronous memory, accumulator and ALU.
  logic [7:0] mem[16];
  logic [7:0] img[16];
  logic [7:0] acc;
  logic       load = 1'b0;
  logic [7:0] alu_b, alu_y;

  always_comb begin
    alu_b = b_sel ? imm : mem_rdata;
    case (alu_op)
      3'd1:    alu_y = acc + alu_b;
      3'd2:    alu_y = acc - alu_b;
      3'd3:    alu_y = acc & alu_b;
      3'd4:    alu_y = acc | alu_b;
      default: alu_y = alu_b;
    endcase
  end
  assign acc_zero = (acc == 8'd0);

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= img[i];
      acc <= 8'd0;
    end else begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= acc;
      if (a_ce) acc <= alu_y;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference interpreter results.
  logic [7:0] ref_mem[16];
  logic [7:0] ref_acc;
  logic [3:0] ref_pc;
  int         ref_cyc, ref_ace, ref_we;
  bit         ref_halt;

  // Observations from the last run.
  int         ace_cyc[$];
  int         we_cyc[$];
  logic [3:0] we_adr[$];
  int         overlap, cyc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic load_img();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic ref_run();
    logic [7:0] w;
    logic [3:0] op, ad;
    ref_mem  = img;
    ref_acc  = 8'd0;
    ref_pc   = 4'd0;
    ref_cyc  = 0;
    ref_ace  = 0;
    ref_we   = 0;
    ref_halt = 1'b0;
    for (int k = 0; k < 64 && !ref_halt; k++) begin
      w  = ref_mem[ref_pc];
      op = w[7:4];
      ad = w[3:0];
      ref_pc  = ref_pc + 4'd1;
      ref_cyc = ref_cyc + 3;
      case (op)
        4'h1: begin ref_acc = ref_mem[ad];           ref_cyc++; ref_ace++; end
        4'h3: begin ref_acc = ref_acc + ref_mem[ad]; ref_cyc++; ref_ace++; end
        4'h4: begin ref_acc = ref_acc - ref_mem[ad]; ref_cyc++; ref_ace++; end
        4'h5: begin ref_acc = ref_acc & ref_mem[ad]; ref_cyc++; ref_ace++; end
        4'h6: begin ref_acc = ref_acc | ref_mem[ad]; ref_cyc++; ref_ace++; end
        4'h2: begin ref_mem[ad] = ref_acc; ref_we++; end
        4'h7: ref_pc = ad;
        4'h8: if (ref_acc == 8'd0) ref_pc = ad;
        4'h9: begin ref_acc = {4'h0, ad}; ref_ace++; end
        4'hF: ref_halt = 1'b1;
        default: ;
      endcase
    end
  endtask

  // Runs img from reset to HALT, optionally poking start while busy, then compares to reference.
  task automatic run_prog(input string tag, input bit poke);
    int bad;
    do_reset();
    load_img();
    ref_run();
    ace_cyc.delete();
    we_cyc.delete();
    we_adr.delete();
    overlap = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!halted && cyc < 1000) begin
      if (a_ce) ace_cyc.push_back(cyc);
      if (mem_we) begin
        we_cyc.push_back(cyc);
        we_adr.push_back(mem_addr);
      end
      if (a_ce && mem_we) overlap++;
      if (poke && busy && $urandom_range(3) == 0) start = 1'b1;
      step();
      start = 1'b0;
      cyc++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s halted: got %b expected 1 (cycle budget)", tag, halted);
    end
    checks++;
    if (cyc !== ref_cyc + 1) begin
      errors++;
      $display("FAIL %s cycles: got %0d expected %0d", tag, cyc, ref_cyc + 1);
    end
    checks++;
    if (acc !== ref_acc) begin
      errors++;
      $display("FAIL %s acc: got %h expected %h", tag, acc, ref_acc);
    end
    checks++;
    if (pc !== ref_pc) begin
      errors++;
      $display("FAIL %s pc: got %h expected %h", tag, pc, ref_pc);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s memory: got %0d differing words expected 0", tag, bad);
    end
    checks++;
    if (ace_cyc.size() !== ref_ace || we_cyc.size() !== ref_we) begin
      errors++;
      $display("FAIL %s strobe counts: got a_ce=%0d we=%0d expected a_ce=%0d we=%0d",
               tag, ace_cyc.size(), we_cyc.size(), ref_ace, ref_we);
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL %s a_ce/mem_we overlap: got %0d cycles expected 0", tag, overlap);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({busy, halted, a_ce, mem_we, mem_rd, pc, mem_addr} !== 13'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got busy=%b halted=%b a_ce=%b we=%b rd=%b pc=%h expected all 0",
                 i, busy, halted, a_ce, mem_we, mem_rd, pc);
      end
    end
  endtask

  task automatic test_program();
    clear_img();
    img[0] = 8'h95; img[1] = 8'h3E; img[2] = 8'h2F; img[3] = 8'hF0; img[14] = 8'h03;
    run_prog("program", 1'b0);
    checks++;
    if (ace_cyc.size() != 2 || ace_cyc[0] !== 3 || ace_cyc[1] !== 7) begin
      errors++;
      $display("FAIL program a_ce timing: got %0d pulses expected cycles 3 and 7", ace_cyc.size());
    end
    checks++;
    if (we_cyc.size() != 1 || we_cyc[0] !== 10 || we_adr[0] !== 4'hF) begin
      errors++;
      $display("FAIL program mem_we timing: got %0d pulses expected one at cycle 10 addr F",
               we_cyc.size());
    end
    checks++;
    if (mem[15] !== 8'h08 || pc !== 4'h4) begin
      errors++;
      $display("FAIL program result: got M[F]=%h pc=%h expected 08 and 4", mem[15], pc);
    end
  endtask

  task automatic test_jz();
    clear_img();
    img[0] = 8'h92; img[1] = 8'h4E; img[2] = 8'h86; img[3] = 8'h91;
    img[4] = 8'hF0; img[5] = 8'h00; img[6] = 8'hF0; img[14] = 8'h02;
    run_prog("jz_taken", 1'b0);
    checks++;
    if (pc !== 4'h7 || acc !== 8'h00 || ace_cyc.size() != 2) begin
      errors++;
      $display("FAIL jz_taken: got pc=%h acc=%h loads=%0d expected 7 00 2", pc, acc, ace_cyc.size());
    end
    img[14] = 8'h01;
    run_prog("jz_not_taken", 1'b0);
    checks++;
    if (pc !== 4'h5 || acc !== 8'h01) begin
      errors++;
      $display("FAIL jz_not_taken: got pc=%h acc=%h expected 5 01", pc, acc);
    end
  endtask

  task automatic test_wrap();
    clear_img();
    img[0] = 8'h7F;
    do_reset();
    load_img();
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    checks++;
    if (pc !== 4'hF) begin
      errors++;
      $display("FAIL wrap jmp: got pc=%h expected F", pc);
    end
    step(); step();
    checks++;
    if (pc !== 4'h0) begin
      errors++;
      $display("FAIL wrap pc: got pc=%h expected 0", pc);
    end
    step();
    checks++;
    if (busy !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 4'h0) begin
      errors++;
      $display("FAIL wrap refetch: got busy=%b rd=%b addr=%h expected 1 1 0", busy, mem_rd, mem_addr);
    end
    do_reset();
  endtask

  task automatic test_reset_sta();
    clear_img();
    img[0] = 8'h97; img[1] = 8'h2E; img[2] = 8'hF0; img[14] = 8'h55;
    do_reset();
    load_img();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 4'hE) begin
      errors++;
      $display("FAIL rst_sta setup: got we=%b addr=%h expected 1 E", mem_we, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || a_ce !== 1'b0) begin
      errors++;
      $display("FAIL rst_sta strobes: got we=%b a_ce=%b expected 0 0", mem_we, a_ce);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || pc !== 4'h0 || mem[14] !== 8'h55) begin
      errors++;
      $display("FAIL rst_sta recover: got busy=%b halted=%b pc=%h M[E]=%h expected 0 0 0 55",
               busy, halted, pc, mem[14]);
    end
  endtask

  task automatic test_halt_restart();
    clear_img();
    img[0] = 8'hB3; img[1] = 8'hF0;
    run_prog("undef_op", 1'b1);
    checks++;
    if (ace_cyc.size() != 0 || we_cyc.size() != 0 || cyc !== 7) begin
      errors++;
      $display("FAIL undef_op: got loads=%0d writes=%0d cycles=%0d expected 0 0 7",
               ace_cyc.size(), we_cyc.size(), cyc);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || halted !== 1'b0 || pc !== 4'h0 || mem_rd !== 1'b1 || mem_addr !== 4'h0) begin
      errors++;
      $display("FAIL halt_restart: got busy=%b halted=%b pc=%h rd=%b addr=%h expected 1 0 0 1 0",
               busy, halted, pc, mem_rd, mem_addr);
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      int tries;
      tries = 0;
      do begin
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        ref_run();
        tries++;
      end while (!ref_halt && tries < 500);
      if (!ref_halt) begin
        clear_img();
        img[0] = 8'hF0;
      end
      run_prog($sformatf("random%0d", n), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_jz();
    test_wrap();
    test_reset_sta();
    test_halt_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_ctrl_seq.md
Name: acc_ctrl_seq

Overview:
Multi-cycle control unit for the 8-bit accumulator datapath. It fetches instruction words from a synchronous program/data memory and decodes them. It then sequences the ALU, the accumulator load enable (A_ce) and memory read/write strobes. It owns the program counter and instruction register; the datapath owns the accumulator, ALU and memory data buses.

Parameters:
DATA_W, 8, data/instruction word width; must match the accumulator width
ADDR_W, 4, memory address width; DATA_W-4 >= ADDR_W required
OPC_W, 4, opcode field width = ir[DATA_W-1 -: OPC_W]

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  1-cycle pulse; starts execution from IDLE or HALT
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_rd
acc_zero  in  1  accumulator == 0, from datapath
mem_addr  out  ADDR_W  memory address
mem_rd  out  1  memory read strobe
mem_we  out  1  memory write strobe; datapath drives accumulator as write data
a_ce  out  1  accumulator load enable
alu_op  out  3  0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR
b_sel  out  1  ALU B operand: 0 mem_rdata, 1 imm
imm  out  DATA_W  ir[ADDR_W-1:0] zero-extended
pc  out  ADDR_W  program counter
busy  out  1  high in FETCH/DECODE/MEM_RD/EXEC
halted  out  1  high in HALT

Behaviour:
- Instruction format: opcode = top OPC_W bits; addr/imm field = ir[ADDR_W-1:0].
- Opcodes:
  - 0 NOP
  - 1 LDA (A<=M[addr])
  - 2 STA (M[addr]<=A)
  - 3 ADD
  - 4 SUB (A-M)
  - 5 AND
  - 6 OR
  - 7 JMP
  - 8 JZ (jump if acc_zero)
  - 9 LDI (A<=imm)
  - F HLT
  - Undefined opcodes execute as NOP.
- FSM states: IDLE, FETCH, DECODE, MEM_RD, EXEC, HALT. Reset sets state=IDLE, pc=0, ir=0.
- Outputs are combinational from state+ir and forced to 0 while rst=1. Default for every output is 0, mem_addr=pc.
- IDLE: start -> FETCH.
- FETCH: mem_addr=pc, mem_rd=1 -> DECODE.
- DECODE: ir<=mem_rdata; pc<=pc+1, wrapping modulo 2^ADDR_W. Next state from mem_rdata opcode:
  - LDA/ADD/SUB/AND/OR -> MEM_RD
  - all others -> EXEC
- MEM_RD: mem_addr=ir.addr, mem_rd=1 -> EXEC.
- EXEC:
  - LDA/ADD/SUB/AND/OR: a_ce=1, b_sel=0, alu_op per opcode.
  - LDI: a_ce=1, b_sel=1, alu_op=PASS_B.
  - STA: mem_addr=ir.addr, mem_we=1.
  - JMP: pc<=ir.addr.
  - JZ: pc<=ir.addr if acc_zero sampled this cycle, else pc unchanged.
  - HLT -> HALT; all others -> FETCH.
- HALT: halted=1, pc frozen. start -> pc<=0, FETCH.
- start is ignored while busy.
- Latency: 3 cycles per instruction (FETCH/DECODE/EXEC); 4 cycles for memory-operand ops.
- a_ce and mem_we are each asserted for exactly one cycle per instruction, never together.
- ALU wrap-around is the datapath's concern; the controller imposes no flags.
- pc wraps from 2^ADDR_W-1 to 0 without stopping.
- Reset mid-instruction: strobes drop in the same cycle rst is high, no partial write. The FSM returns to IDLE and pc=0.

Test Plan:
- Reset then idle: rst 2 cycles, no start -> state IDLE, pc=0, all strobes 0, busy=0, halted=0 for 10 cycles.
- Program {LDI 5, ADD M[E], STA M[F], HLT}, M[E]=3, start pulse -> a_ce in cycles 3 and 7, mem_we with mem_addr=F in cycle 10, M[F]=8, halted=1, pc=4.
- SUB to zero then JZ: {LDI 2, SUB M[E](=2), JZ 6, LDI 1, HLT, NOP, HLT} -> pc jumps to 6, accumulator 0, never loads 1; repeat with M[E]=1 -> JZ not taken, accumulator 1.
- Wrap: JMP F at pc 0, NOP at F -> pc goes F -> 0 after DECODE, execution continues from 0.
- Reset during EXEC of STA (rst high in the mem_we cycle) -> mem_we=0 that cycle, memory unchanged, state IDLE, pc=0.
- start pulses while busy are ignored; start in HALT restarts at pc=0; undefined opcode 0xB executes as NOP with no strobes.
